// File: rtl/fifo_init_ctrl.sv
// fifo_init_ctrl: sequences a 1-cycle-latency dual-port RAM as a FIFO, optionally pre-filled with 0..DEPTH-1
module fifo_init_ctrl #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 16,
    parameter bit INIT_FILL  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic                  pop_valid,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  init_done,
    output logic                  push_err,
    output logic                  pop_err,
    output logic [ADDR_WIDTH-1:0] ram_waddr,
    output logic                  ram_we,
    output logic [DATA_WIDTH-1:0] ram_din,
    output logic [ADDR_WIDTH-1:0] ram_raddr,
    output logic                  ram_re,
    input  logic [DATA_WIDTH-1:0] ram_dout
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    typedef enum logic {INIT, RUN} state_t;
    state_t                state, state_nxt;
    logic [ADDR_WIDTH:0]   wptr, rptr, cnt_raw;
    logic [ADDR_WIDTH-1:0] ctr;
    logic                  run, in_init, push_acc, pop_acc;
    always_ff @(posedge clk)
        state <= rst ? (INIT_FILL ? INIT : RUN) : state_nxt;
    always_comb
        state_nxt = (state == INIT && &ctr) ? RUN : state;
    always_comb begin
        run       = !rst && state == RUN;
        in_init   = !rst && state == INIT;
        cnt_raw   = wptr - rptr;
        count     = run ? cnt_raw : '0;
        full      = run && cnt_raw == (ADDR_WIDTH+1)'(DEPTH);
        empty     = !run || cnt_raw == '0;
        init_done = run;
        push_acc  = run && push && !full;
        pop_acc   = run && pop && !empty;
        ram_we    = in_init || push_acc;
        ram_waddr = in_init ? ctr : wptr[ADDR_WIDTH-1:0];
        ram_din   = in_init ? DATA_WIDTH'(ctr) : push_data;
        ram_re    = pop_acc;
        ram_raddr = rptr[ADDR_WIDTH-1:0];
        pop_data  = ram_dout;
    end
    // init leaves the FIFO full: wptr lands one full lap ahead of rptr
    always_ff @(posedge clk)
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            ctr       <= '0;
            pop_valid <= 1'b0;
            push_err  <= 1'b0;
            pop_err   <= 1'b0;
        end else begin
            ctr       <= (state == INIT) ? ctr + 1'b1 : ctr;
            wptr      <= (state == INIT && state_nxt == RUN) ? (ADDR_WIDTH+1)'(DEPTH) :
                         push_acc ? wptr + 1'b1 : wptr;
            rptr      <= pop_acc ? rptr + 1'b1 : rptr;
            pop_valid <= pop_acc;
            push_err  <= push_err | (push & !push_acc);
            pop_err   <= pop_err | (pop & !pop_acc);
        end
endmodule

// File: tb/tb_fifo_init_ctrl.sv
// tb_fifo_init_ctrl: checks init fill, FIFO ordering, error flags and reset with a bench RAM and a scoreboard
module tb_fifo_init_ctrl;
    logic        clk = 1'b0, rst = 1'b1, push = 1'b0, pop = 1'b0;
    logic [15:0] push_data = '0, pop_data, ram_din, ram_dout = '0;
    logic        pop_valid, full, empty, init_done, push_err, pop_err, ram_we, ram_re;
    logic [3:0]  count;
    logic [2:0]  ram_waddr, ram_raddr;
    logic        u1_push = 1'b0, u1_pop = 1'b0;
    logic [15:0] u1_push_data = '0, u1_ram_dout = '0, u1_pop_data, u1_ram_din;
    logic        u1_pop_valid, u1_full, u1_empty, u1_init_done, u1_push_err, u1_pop_err, u1_ram_we, u1_ram_re;
    logic [3:0]  u1_count;
    logic [2:0]  u1_ram_waddr, u1_ram_raddr;
    logic [15:0] mem [8];
    logic [15:0] mq[$], expq[$];
    logic [3:0]  m_w = '0;
    int          tests = 0, failed = 0;

    typedef struct {
        logic        p, q;
        logic [15:0] d;
        logic [3:0]  cnt;
        logic        f, e, perr, oerr;
    } vec_t;
    vec_t tbl[$];

    fifo_init_ctrl #(.ADDR_WIDTH(3), .DATA_WIDTH(16), .INIT_FILL(1'b1)) dut (
        .clk(clk), .rst(rst), .push(push), .push_data(push_data), .pop(pop),
        .pop_data(pop_data), .pop_valid(pop_valid), .full(full), .empty(empty),
        .count(count), .init_done(init_done), .push_err(push_err), .pop_err(pop_err),
        .ram_waddr(ram_waddr), .ram_we(ram_we), .ram_din(ram_din),
        .ram_raddr(ram_raddr), .ram_re(ram_re), .ram_dout(ram_dout));

    fifo_init_ctrl #(.ADDR_WIDTH(3), .DATA_WIDTH(16), .INIT_FILL(1'b0)) u1 (
        .clk(clk), .rst(rst), .push(u1_push), .push_data(u1_push_data), .pop(u1_pop),
        .pop_data(u1_pop_data), .pop_valid(u1_pop_valid), .full(u1_full), .empty(u1_empty),
        .count(u1_count), .init_done(u1_init_done), .push_err(u1_push_err), .pop_err(u1_pop_err),
        .ram_waddr(u1_ram_waddr), .ram_we(u1_ram_we), .ram_din(u1_ram_din),
        .ram_raddr(u1_ram_raddr), .ram_re(u1_ram_re), .ram_dout(u1_ram_dout));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) mem[ram_waddr] <= ram_din;
        if (ram_re) ram_dout <= mem[ram_raddr];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // one RUN-state cycle, entered and left at a negedge
    task automatic cycle(input logic p, input logic q, input logic [15:0] d);
        logic pa, qa;
        pa = p && mq.size() < 8;
        qa = q && mq.size() > 0;
        push = p; pop = q; push_data = d;
        #1;
        chk("ram_we", ram_we, pa);
        chk("ram_re", ram_re, qa);
        if (pa) begin
            chk("ram_waddr", ram_waddr, m_w[2:0]);
            chk("ram_din", ram_din, d);
        end
        if (qa) expq.push_back(mq.pop_front());
        if (pa) begin
            mq.push_back(d);
            m_w++;
        end
        @(negedge clk);
        push = 1'b0; pop = 1'b0;
        chk("pop_valid", pop_valid, qa);
        if (qa) chk("pop_data", pop_data, expq.pop_front());
        chk("count_model", count, mq.size());
    endtask

    task automatic run_tbl();
        foreach (tbl[i]) begin
            cycle(tbl[i].p, tbl[i].q, tbl[i].d);
            chk($sformatf("tbl%0d_count", i), count, tbl[i].cnt);
            chk($sformatf("tbl%0d_full", i), full, tbl[i].f);
            chk($sformatf("tbl%0d_empty", i), empty, tbl[i].e);
            chk($sformatf("tbl%0d_push_err", i), push_err, tbl[i].perr);
            chk($sformatf("tbl%0d_pop_err", i), pop_err, tbl[i].oerr);
        end
        tbl.delete();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_init_done", init_done, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_ram_re", ram_re, 0);
        chk("rst_pop_valid", pop_valid, 0);
        chk("u1_rst_init_done", u1_init_done, 0);
        rst = 1'b0;
        #1;
        chk("u1_init_done", u1_init_done, 1);
        chk("u1_empty", u1_empty, 1);
        // requests during init are dropped and flagged; then reset at init cycle 3
        for (int i = 0; i < 3; i++) begin
            push = 1'b1; pop = 1'b1;
            #1;
            chk("init_pre_waddr", ram_waddr, i);
            chk("init_pre_re", ram_re, 0);
            @(negedge clk);
        end
        chk("init_push_err", push_err, 1);
        chk("init_pop_err", pop_err, 1);
        rst = 1'b1;
        #1;
        chk("rst_mid_init_we", ram_we, 0);
        @(negedge clk);
        push = 1'b0; pop = 1'b0;
        chk("rst_clr_push_err", push_err, 0);
        chk("rst_clr_pop_err", pop_err, 0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("init_we", ram_we, 1);
            chk("init_waddr", ram_waddr, i);
            chk("init_din", ram_din, i);
            chk("init_done_low", init_done, 0);
            chk("init_count", count, 0);
            chk("init_empty", empty, 1);
            chk("init_full", full, 0);
            @(negedge clk);
        end
        chk("post_init_done", init_done, 1);
        chk("post_init_full", full, 1);
        chk("post_init_count", count, 8);
        for (int i = 0; i < 8; i++) mq.push_back(16'(i));
        m_w = 4'd8;
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 16'h0);
        chk("drain_empty", empty, 1);
        chk("drain_count", count, 0);
        tbl.push_back('{1'b1, 1'b0, 16'hABCD, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 16'h0000, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0});
        for (int i = 1; i <= 4; i++)
            tbl.push_back('{1'b1, 1'b0, 16'h0100 + 16'(i), 4'(i), 1'b0, 1'b0, 1'b0, 1'b0});
        run_tbl();
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 1'b1, 16'h0200 + 16'(i));
            chk("steady_count", count, 4);
        end
        chk("steady_push_err", push_err, 0);
        chk("steady_pop_err", pop_err, 0);
        for (int i = 5; i <= 8; i++)
            tbl.push_back('{1'b1, 1'b0, 16'h0300 + 16'(i), 4'(i), i == 8, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 16'h0399, 4'd8, 1'b1, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 16'h0398, 4'd7, 1'b0, 1'b0, 1'b1, 1'b0});
        for (int i = 6; i >= 0; i--)
            tbl.push_back('{1'b0, 1'b1, 16'h0000, 4'(i), 1'b0, i == 0, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 16'h0000, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1});
        tbl.push_back('{1'b1, 1'b1, 16'h0501, 4'd1, 1'b0, 1'b0, 1'b1, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 16'h0000, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1});
        tbl.push_back('{1'b1, 1'b0, 16'h0601, 4'd1, 1'b0, 1'b0, 1'b1, 1'b1});
        tbl.push_back('{1'b1, 1'b0, 16'h0602, 4'd2, 1'b0, 1'b0, 1'b1, 1'b1});
        run_tbl();
        // reset in the middle of traffic with requests still asserted
        rst = 1'b1; push = 1'b1; pop = 1'b1;
        #1;
        chk("rst_run_we", ram_we, 0);
        chk("rst_run_re", ram_re, 0);
        chk("rst_run_count", count, 0);
        chk("rst_run_empty", empty, 1);
        chk("rst_run_init_done", init_done, 0);
        @(negedge clk);
        push = 1'b0; pop = 1'b0;
        chk("rst_run_push_err", push_err, 0);
        chk("rst_run_pop_err", pop_err, 0);
        chk("rst_run_pop_valid", pop_valid, 0);
        rst = 1'b0;
        #1;
        chk("reinit_we", ram_we, 1);
        chk("reinit_waddr", ram_waddr, 0);
        chk("reinit_din", ram_din, 0);
        chk("reinit_done", init_done, 0);
        chk("u1_reinit_done", u1_init_done, 1);
        chk("u1_reinit_empty", u1_empty, 1);
        chk("scoreboard_drained", expq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/fifo_init_ctrl.md
Name: fifo_init_ctrl

Overview:
Sequencing controller for a single-clock dual-port synchronous RAM with 1-cycle registered read latency and no read/write bypass. It turns the RAM into a synchronous FIFO by generating all RAM read/write addresses and strobes, and tracking occupancy. With INIT_FILL set, it first pre-loads the RAM with the indices 0..DEPTH-1, so the FIFO comes up full and can serve as the switch's free-buffer-address list.

Parameters:
ADDR_WIDTH, 9, RAM address width; DEPTH = 2**ADDR_WIDTH.
DATA_WIDTH, 16, data width; must be >= ADDR_WIDTH when INIT_FILL=1.
INIT_FILL, 1, 1 = run the index pre-load after reset; 0 = come up empty.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
push  in  1  write request
push_data  in  DATA_WIDTH  write data
pop  in  1  read request
pop_data  out  DATA_WIDTH  read data, equal to ram_dout
pop_valid  out  1  pop_data valid this cycle
full  out  1  count == DEPTH
empty  out  1  count == 0
count  out  ADDR_WIDTH+1  occupancy
init_done  out  1  high once in RUN state
push_err  out  1  sticky: push rejected
pop_err  out  1  sticky: pop rejected
ram_waddr  out  ADDR_WIDTH  RAM write address
ram_we  out  1  RAM write enable
ram_din  out  DATA_WIDTH  RAM write data
ram_raddr  out  ADDR_WIDTH  RAM read address
ram_re  out  1  RAM read enable
ram_dout  in  DATA_WIDTH  RAM read data, valid 1 cycle after ram_re

Behaviour:
- Pointers wptr and rptr are each ADDR_WIDTH+1 bits; the MSB is the wrap bit. RAM addresses use the low ADDR_WIDTH bits.
- count = wptr - rptr, taken modulo 2**(ADDR_WIDTH+1).
- States: INIT, RUN.
- Reset (any cycle, including mid-init or mid-traffic):
  - INIT_FILL=1: state=INIT, init counter=0.
  - INIT_FILL=0: state=RUN.
  - In both cases: wptr=0, rptr=0, pop_valid=0, push_err=0, pop_err=0.
  - Outputs while rst is high: count=0, empty=1, full=0, init_done=0, ram_we=0, ram_re=0.
- INIT state:
  - Each cycle: ram_we=1, ram_waddr=ctr, ram_din=ctr zero-extended; ctr increments.
  - Lasts exactly DEPTH cycles, then moves to RUN with wptr=DEPTH (wrap bit 1, low bits 0) and rptr=0.
  - Throughout INIT: init_done=0, full=0, empty=1, count=0, ram_re=0.
  - push or pop during INIT are ignored and set the matching err flag.
- RUN state:
  - init_done=1.
  - push_acc = push & ~full.
  - pop_acc = pop & ~empty.
  - ram_we = push_acc, with ram_waddr=wptr[low] and ram_din=push_data (combinational from inputs).
  - ram_re = pop_acc, with ram_raddr=rptr[low] (combinational).
  - On an accepted push, wptr increments on the clock edge; on an accepted pop, rptr increments.
- Latency: pop_valid is a registered copy of pop_acc. pop_data=ram_dout, valid 1 cycle after pop. Push-to-visible (empty deasserts) is 1 cycle.
- Simultaneous push and pop with 0 < count < DEPTH: both accepted; count unchanged.
- push while full: rejected, sets push_err, even if pop is high in the same cycle (no pass-through).
- pop while empty: rejected, sets pop_err, even if push is high in the same cycle.
- A same-address read/write in one cycle is therefore impossible; no bypass is required.
- Wrap-around: pointers increment modulo 2**(ADDR_WIDTH+1); address low bits wrap from DEPTH-1 to 0.
- push_err and pop_err are cleared only by rst.

Test Plan:
1. ADDR_WIDTH=3, INIT_FILL=1; release rst -> ram_we high for 8 cycles with addr/data 0..7. init_done rises the next cycle with full=1, count=8.
2. After init, pop 8 back-to-back cycles -> pop_valid on 8 cycles with pop_data 0,1,...,7, each 1 cycle after its pop. Then empty=1, count=0.
3. From empty, push 0xABCD then pop -> empty=0 the cycle after the push. pop_data=0xABCD with pop_valid=1 one cycle after the pop.
4. Hold count=4 and drive push+pop together for 20 cycles with incrementing data -> count stays 4, output order matches input order across the address wrap, no err flags set.
5. Push while full (with pop=0 and again with pop=1), and pop while empty -> push_err and pop_err set and sticky, pointers unchanged, only the pop is accepted in the full+pop case.
6. Assert rst at init cycle 3, and again mid-traffic -> init restarts at addr 0, err flags cleared. With INIT_FILL=0: init_done=1 and empty=1 on the first cycle after rst.
